data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers CPU load/store requests over a
// valid/ready handshake, after a fixed number of wait states.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          acc_en;
    logic          acc_write;
    logic          acc_fault;
    logic          mem_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        acc_en    = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Zero wait states: the access happens on the accepting edge,
                    // so it must use the live request rather than the captures.
                    if (WAIT_CYCLES == 0) begin
                        acc_en    = 1'b1;
                        acc_write = req_write;
                        acc_addr  = req_addr;
                        acc_wdata = req_wdata;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Full 30-bit word index is range-checked, so high addresses never alias.
        acc_fault = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_W);
        acc_idx   = acc_addr[AW+1:2];
        mem_we    = acc_en && acc_write && !acc_fault && !reset;

        if (acc_en) begin
            err_d   = acc_fault;
            rdata_d = (acc_write || acc_fault) ? '0 : mem[acc_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a
// randomized load/store mix against an associative-array memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        w0_req_valid, w0_req_write, w0_req_ready, w0_resp_valid, w0_resp_ready, w0_resp_err;
    logic [31:0] w0_req_addr, w0_req_wdata, w0_resp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(w0_req_valid), .req_write(w0_req_write), .req_addr(w0_req_addr), .req_wdata(w0_req_wdata),
        .req_ready(w0_req_ready), .resp_valid(w0_resp_valid), .resp_ready(w0_resp_ready),
        .resp_rdata(w0_resp_rdata), .resp_err(w0_resp_err)
    );

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    // Drives one transaction and reports what was observed; callers compare.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int bp,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int wait_n, output bit held_ok, output bit done_ok);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
        wait_n = 0;
        while (!req_ready && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk); #1;
        req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
        req_valid = 1'($urandom_range(0, 1));
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err; held_ok = 1'b1;
        repeat (bp) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
                held_ok = 1'b0;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        done_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        w0_req_valid = 1'b0; w0_req_write = 1'b0; w0_req_addr = '0; w0_req_wdata = '0; w0_resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL first_edge_accept: req_ready got %b want 0", req_ready); end
        n = 0;
        while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n != WAIT) begin errors++; $display("FAIL first_edge_latency: got %0d want %0d", n, WAIT); end
        checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0)
            begin errors++; $display("FAIL first_edge_fault: err %b rdata %h want err 1 rdata 0", resp_err, resp_rdata); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, wn; bit h, dn;
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, wn, h, dn);
        checks++; if (lat != WAIT) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, WAIT); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_resp: rdata %h err %b want 0/0", rd, er); end
        checks++; if (!dn) begin errors++; $display("FAIL store_consume: got 0 want 1"); end
        model[4] = 32'hDEADBEEF;
        run_txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (lat != WAIT) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, WAIT); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0)
            begin errors++; $display("FAIL load_data: rdata %h err %b want deadbeef/0", rd, er); end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic er; int lat, wn; bit h, dn;
        run_txn(1'b1, 32'h0, 32'hA5A5_0000, 0, rd, er, lat, wn, h, dn);   model[0] = 32'hA5A5_0000;
        run_txn(1'b1, 32'h3FC, 32'h5A5A_00FF, 0, rd, er, lat, wn, h, dn); model[255] = 32'h5A5A_00FF;
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_store_err: got %b want 0", er); end
        run_txn(1'b0, 32'h13, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_load: err %b rdata %h want 1/0", er, rd); end
        run_txn(1'b0, 32'h400, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_load: err %b rdata %h want 1/0", er, rd); end
        run_txn(1'b1, 32'h401, 32'h11111111, 0, rd, er, lat, wn, h, dn);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_store: err %b rdata %h want 1/0", er, rd); end
        run_txn(1'b1, 32'h8000_0000, 32'h2222_2222, 0, rd, er, lat, wn, h, dn);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL high_addr_store: err %b want 1", er); end
        run_txn(1'b0, 32'h400, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oob_reload: err %b want 1", er); end
        run_txn(1'b0, 32'h0, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (rd !== model[0] || er !== 1'b0) begin errors++; $display("FAIL no_alias_word0: rdata %h want %h", rd, model[0]); end
        run_txn(1'b0, 32'h3FC, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (rd !== model[255] || er !== 1'b0) begin errors++; $display("FAIL no_alias_word255: rdata %h want %h", rd, model[255]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat, wn; bit h, dn;
        run_txn(1'b0, 32'h10, 32'h0, 5, rd, er, lat, wn, h, dn);
        checks++; if (!h) begin errors++; $display("FAIL backpressure_hold: got 0 want 1"); end
        checks++; if (rd !== model[4]) begin errors++; $display("FAIL backpressure_data: got %h want %h", rd, model[4]); end
        checks++; if (!dn) begin errors++; $display("FAIL backpressure_release: got 0 want 1"); end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic er; int lat, wn; bit h, dn;
        run_txn(1'b1, 32'h20, 32'h12345678, 0, rd, er, lat, wn, h, dn); model[8] = 32'h12345678;
        run_txn(1'b0, 32'h20, 32'h0, 0, rd, er, lat, wn, h, dn);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || resp_rdata !== 32'h12345678)
            begin errors++; $display("FAIL mid_store_busy: ready %b rdata %h want 0/12345678", req_ready, resp_rdata); end
        #2 reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
            begin errors++; $display("FAIL async_reset: ready %b valid %b rdata %h err %b want 1/0/0/0",
                                     req_ready, resp_valid, resp_rdata, resp_err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b0, 32'h20, 32'h0, 0, rd, er, lat, wn, h, dn);
        checks++; if (rd !== 32'h12345678 || er !== 1'b0)
            begin errors++; $display("FAIL abandoned_store: rdata %h want 12345678", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, wn; bit h, dn;
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            run_txn(1'b1, 32'd200, v, 0, rd, er, lat, wn, h, dn); model[50] = v;
            run_txn(1'b0, 32'd200, 32'h0, 0, rd, er, lat, wn, h, dn);
            checks++; if (wn != 0) begin errors++; $display("FAIL b2b_accept_wait: got %0d want 0", wn); end
            checks++; if (rd !== v) begin errors++; $display("FAIL b2b_data: got %h want %h", rd, v); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat, wn; bit h, dn;
        logic [31:0] a, d, exp_rd;
        logic w;
        int unsigned pool [8] = '{0, 1, 4, 8, 100, 200, 254, 255};
        logic [31:0] bad [5] = '{32'h400, 32'h402, 32'h8000_0010, 32'hFFFF_FFFC, 32'h4000_0000};
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case ($urandom_range(0, 9))
                7:       a = bad[$urandom_range(0, 4)];
                8:       a = ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
                default: a = pool[$urandom_range(0, 7)] * 4;
            endcase
            run_txn(w, a, d, $urandom_range(0, 3), rd, er, lat, wn, h, dn);
            exp_rd = 32'h0;
            if (!is_fault(a)) begin
                if (w) model[a / 4] = d;
                else if (model.exists(a / 4)) exp_rd = model[a / 4];
                else exp_rd = rd;
            end
            checks++; if (er !== 1'(is_fault(a))) begin errors++; $display("FAIL rand_err a=%h: got %b want %b", a, er, is_fault(a)); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata a=%h w=%b: got %h want %h", a, w, rd, exp_rd); end
            checks++; if (lat != WAIT) begin errors++; $display("FAIL rand_latency: got %0d want %0d", lat, WAIT); end
            checks++; if (!h || !dn) begin errors++; $display("FAIL rand_handshake: hold %b done %b want 1/1", h, dn); end
        end
    endtask

    task automatic test_wait0();
        logic [31:0] v;
        v = $urandom;
        @(negedge clk);
        w0_req_valid = 1'b1; w0_req_write = 1'b1; w0_req_addr = 32'h40; w0_req_wdata = v; w0_resp_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (w0_resp_valid !== 1'b1) begin errors++; $display("FAIL w0_latency: got %b want 1", w0_resp_valid); end
        w0_req_write = 1'b0; w0_req_wdata = $urandom;
        @(posedge clk); #1;
        checks++; if (w0_resp_valid !== 1'b1 || w0_req_ready !== 1'b0)
            begin errors++; $display("FAIL w0_held_in_resp: valid %b ready %b want 1/0", w0_resp_valid, w0_req_ready); end
        w0_resp_ready = 1'b1;
        @(posedge clk); #1;
        w0_resp_ready = 1'b0;
        checks++; if (w0_resp_valid !== 1'b0 || w0_req_ready !== 1'b1)
            begin errors++; $display("FAIL w0_consume_no_accept: valid %b ready %b want 0/1", w0_resp_valid, w0_req_ready); end
        @(posedge clk); #1;
        w0_req_valid = 1'b0;
        checks++; if (w0_resp_valid !== 1'b1 || w0_resp_rdata !== v || w0_resp_err !== 1'b0)
            begin errors++; $display("FAIL w0_load: valid %b rdata %h err %b want 1/%h/0", w0_resp_valid, w0_resp_rdata, w0_resp_err, v); end
        w0_resp_ready = 1'b1;
        @(posedge clk); #1;
        w0_resp_ready = 1'b0;
        checks++; if (w0_req_ready !== 1'b1) begin errors++; $display("FAIL w0_idle: got %b want 1", w0_req_ready); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_faults();
        test_backpressure();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
